// File: rtl/rnn_bias_stream.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rnn_bias_stream
// Writable multi-layer bias store plus a streaming bias-add stage. It sits
// between the MAC array output and the activation unit. The host loads
// LAYERS x DEPTH signed biases through the load port. A start pulse makes the
// block walk one layer's biases in index order. Each bias is added to the
// accumulator element taken from the input stream, and the saturated sum is
// emitted downstream one cycle later.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ld_en/ld_layer/ld_addr/ld_data
//                            bias write port, usable in any state
//   start, start_layer       begin one DEPTH-element pass on a layer
//   busy                     pass in progress (RUN or DRAIN)
//   in_valid/in_ready/in_acc input accumulator stream
//   out_valid/out_ready      output handshake
//   out_data                 sat(in_acc + bias)
//   out_idx                  neuron index of out_data
//   out_last                 high with element DEPTH-1
//   sat_flag                 element's sum was clamped
// ---------------------------------------------------------------------------
module rnn_bias_stream #(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 32,
   parameter  int LAYERS = 2,
   localparam int AW     = $clog2(DEPTH),
   localparam int LW     = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_en,
   input  logic [LW-1:0]    ld_layer,
   input  logic [AW-1:0]    ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             start,
   input  logic [LW-1:0]    start_layer,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    out_idx,
   output logic             out_last,
   output logic             sat_flag
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [LW-1:0]    layer_q, layer_d;
   logic [WIDTH-1:0] bias_q [LAYERS][DEPTH];
   logic [WIDTH-1:0] bias_d [LAYERS][DEPTH];
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [AW-1:0]    out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             sat_q, sat_d;

   logic                    in_ready_int;
   logic                    accept;
   logic                    ld_ok;
   logic                    start_layer_ok;
   logic [WIDTH-1:0]        bias_rd;
   logic signed [WIDTH:0]   sum;
   logic                    overflow;
   logic [WIDTH-1:0]        sum_sat;

   // Input is taken only while walking a layer and when the output register
   // is free or being emptied this cycle.
   assign in_ready_int = (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept       = in_valid && in_ready_int;

   // Range checks widen to 32 bits so non-power-of-two sizes work too.
   assign ld_ok          = (32'(ld_layer) < 32'(LAYERS)) && (32'(ld_addr) < 32'(DEPTH));
   assign start_layer_ok = 32'(start_layer) < 32'(LAYERS);

   // Read the registered store, so a same-cycle write is seen only by
   // later reads.
   assign bias_rd = bias_q[layer_q][idx_q];

   // One extra bit of headroom: a mismatch between the top two bits means
   // the true sum left the WIDTH-bit range. The top bit gives the side.
   always_comb begin
      sum      = $signed({in_acc[WIDTH-1], in_acc}) + $signed({bias_rd[WIDTH-1], bias_rd});
      overflow = sum[WIDTH] != sum[WIDTH-1];
      sum_sat  = sum[WIDTH-1:0];
      if (overflow) begin
         sum_sat = sum[WIDTH] ? SAT_MIN : SAT_MAX;
      end
   end

   // Bias store next state: one write per cycle, out-of-range writes dropped.
   always_comb begin
      bias_d = bias_q;
      if (ld_en && ld_ok) begin
         bias_d[ld_layer][ld_addr] = ld_data;
      end
   end

   // Control and output register next state. A handshake empties the output
   // register. An accept in the same cycle refills it with the next element.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      layer_d     = layer_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      sat_d       = sat_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_idx_d   = '0;
         out_last_d  = 1'b0;
         sat_d       = 1'b0;
      end

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = sum_sat;
         out_idx_d   = idx_q;
         out_last_d  = (idx_q == LAST_IDX);
         sat_d       = overflow;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               idx_d   = '0;
               layer_d = start_layer_ok ? start_layer : '0;
            end
         end
         RUN: begin
            if (accept) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = DRAIN;
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         DRAIN: begin
            if (out_valid_q && out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state, including the bias store, clears immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         layer_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         sat_q       <= 1'b0;
         for (int l = 0; l < LAYERS; l++) begin
            for (int a = 0; a < DEPTH; a++) begin
               bias_q[l][a] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         layer_q     <= layer_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         sat_q       <= sat_d;
         bias_q      <= bias_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign in_ready  = in_ready_int;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign sat_flag  = sat_q;

endmodule
